// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op encodings, FSM states, default width.
// ALU_SEQ_DIV_EN selects whether DIVU/REMU are iterative ops or undefined.
package alu_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared iterative datapath: shift-add multiplier and (with ALU_SEQ_DIV_EN)
// restoring divider, one bit per cycle over a 2*WIDTH accumulator.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             is_div,
    input  logic             want_rem,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [SHAMT_W:0] LAST = (SHAMT_W+1)'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   opnd_reg, load_lo, load_opnd;
    logic [SHAMT_W:0]   cnt_reg;
    logic               run_reg;
    logic [WIDTH:0]     mul_sum;
`ifdef ALU_SEQ_DIV_EN
    logic               div_reg, rem_reg;
    logic [WIDTH:0]     part;
    logic [WIDTH-1:0]   diff;
`endif

    // done marks the cycle whose edge performs the final iteration
    assign done = run_reg && (cnt_reg == LAST);

    always_comb begin
        load_lo   = b;
        load_opnd = a;
`ifdef ALU_SEQ_DIV_EN
        if (is_div) begin
            load_lo   = a;
            load_opnd = b;
        end
`endif
    end

    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        result   = acc_next[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
        // partial remainder keeps the bit shifted out of the top so it never overflows
        part = acc_reg[2*WIDTH-1:WIDTH-1];
        diff = part[WIDTH-1:0] - opnd_reg;
        if (div_reg) begin
            if (part >= {1'b0, opnd_reg}) begin
                acc_next = {diff, acc_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {part[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
            end
            result = rem_reg ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg  <= '0;
            opnd_reg <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_reg  <= 1'b0;
            rem_reg  <= 1'b0;
`endif
        end else if (start) begin
            acc_reg  <= {{WIDTH{1'b0}}, load_lo};
            opnd_reg <= load_opnd;
            cnt_reg  <= '0;
            run_reg  <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
            div_reg  <= is_div;
            rem_reg  <= want_rem;
`endif
        end else if (run_reg) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + (SHAMT_W+1)'(1);
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: FSM, single-cycle datapath, NZCV flags, output registers.
// Define ALU_SEQ_DIV_EN to build DIVU/REMU; otherwise they behave as undefined ops.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    state_t             state_reg, state_next;
    logic               accept, iter_op, start, iter_done, load;
    logic [WIDTH-1:0]   iter_result, b_eff, sum, alu_res, res_next;
    logic               is_sub, carry, ovf, c_next, v_next;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   result_reg;
    logic               n_reg, z_reg, c_reg, v_reg;

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign iter_op   = is_iter_op(ALUControl);
    assign start     = accept & iter_op;

    alu_seq_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef ALU_SEQ_DIV_EN
        .is_div   ((ALUControl == OP_DIVU) || (ALUControl == OP_REMU)),
        .want_rem (ALUControl == OP_REMU),
`endif
        .a        (A),
        .b        (B),
        .done     (iter_done),
        .result   (iter_result)
    );

    // SUB, SLT and SLTU all share the subtractor
    always_comb begin
        is_sub       = (ALUControl != OP_ADD);
        b_eff        = is_sub ? ~B : B;
        {carry, sum} = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        ovf          = ~(A[WIDTH-1] ^ B[WIDTH-1] ^ is_sub) & (A[WIDTH-1] ^ sum[WIDTH-1]);
        shamt        = B[SHAMT_W-1:0];
        case (ALUControl)
            OP_ADD, OP_SUB: alu_res = sum;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~carry};
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $signed(A) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        res_next = alu_res;
        c_next   = 1'b0;
        v_next   = 1'b0;
        if (state_reg == ST_BUSY) begin
            load     = iter_done;
            res_next = iter_result;
        end else if (accept && !iter_op) begin
            load = 1'b1;
            if ((ALUControl == OP_ADD) || (ALUControl == OP_SUB)) begin
                c_next = carry;
                v_next = ovf;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = iter_op ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            n_reg      <= 1'b0;
            z_reg      <= 1'b0;
            c_reg      <= 1'b0;
            v_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                result_reg <= res_next;
                n_reg      <= res_next[WIDTH-1];
                z_reg      <= (res_next == '0);
                c_reg      <= c_next;
                v_reg      <= v_next;
            end
        end
    end

    assign Result = result_reg;
    assign N      = n_reg;
    assign Z      = z_reg;
    assign C      = c_reg;
    assign V      = v_reg;

endmodule
